// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin burst arbiter sharing one synchronous ROM
// between two requesters; issues consecutive addresses and returns tagged read data.
module rom_burst_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 12,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [LEN_W-1:0]  len0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [LEN_W-1:0]  len1,
   output logic              gnt1,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_id,
   output logic              rd_last,
   output logic              busy
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state_q;
   logic [LEN_W-1:0]  len_q, cnt_q;
   logic              id_q, last_served_q;
   logic              flag_q, flag_id_q, flag_last_q;
   logic              gnt0_q, gnt1_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q, rd_id_q, rd_last_q;

   logic              win1_d;
   logic              cnt_done_d;

   // On a tie the requester that was not served last takes the grant.
   always_comb begin
      win1_d     = req1 & (~req0 | ~last_served_q);
      cnt_done_d = (cnt_q == len_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         len_q         <= '0;
         cnt_q         <= '0;
         id_q          <= 1'b0;
         last_served_q <= 1'b1;
         flag_q        <= 1'b0;
         flag_id_q     <= 1'b0;
         flag_last_q   <= 1'b0;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         rom_addr_q    <= '0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         rd_id_q       <= 1'b0;
         rd_last_q     <= 1'b0;
      end else begin
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         flag_q      <= (state_q == ISSUE);
         flag_id_q   <= id_q;
         flag_last_q <= (state_q == ISSUE) & cnt_done_d;
         rd_valid_q  <= flag_q;
         rd_data_q   <= flag_q ? rom_data : '0;
         rd_id_q     <= flag_q & flag_id_q;
         rd_last_q   <= flag_q & flag_last_q;
         case (state_q)
            IDLE: begin
               if (req0 | req1) begin
                  id_q          <= win1_d;
                  last_served_q <= win1_d;
                  rom_addr_q    <= win1_d ? addr1 : addr0;
                  len_q         <= win1_d ? len1 : len0;
                  cnt_q         <= '0;
                  gnt0_q        <= ~win1_d;
                  gnt1_q        <= win1_d;
                  state_q       <= ISSUE;
               end
            end
            ISSUE: begin
               // Final address stays on the bus; the idle cycle that follows is the bubble.
               if (cnt_done_d) begin
                  state_q <= IDLE;
               end else begin
                  rom_addr_q <= rom_addr_q + 1'b1;
                  cnt_q      <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign rom_addr = rom_addr_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_id    = rd_id_q;
   assign rd_last  = rd_last_q;
   assign busy     = (state_q == ISSUE) | flag_q | rd_valid_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - directed and random stimulus against a cycle-timeline
// reference model of grants, returned words and ROM addresses.
module tb_rom_burst_arbiter;

   localparam int N = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [9:0]  addr0, addr1;
   logic [3:0]  len0, len1;
   logic        gnt0, gnt1;
   logic [9:0]  rom_addr;
   logic [11:0] rom_data = 12'd0;
   logic [11:0] rd_data;
   logic        rd_valid, rd_id, rd_last, busy;

   rom_burst_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0),
      .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id),
      .rd_last(rd_last), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= {2'b00, rom_addr} + 12'd100;

   // Expected outputs per cycle; cycle k is the interval after posedge k.
   bit          e_g0[N], e_g1[N], e_busy[N], e_v[N], e_id[N], e_last[N];
   logic [11:0] e_data[N];
   logic [9:0]  e_ra[N];

   int   cyc, n_tests, n_fail, free_edge, granted;
   logic m_last;
   bit   hold0, hold1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge(input int k);
      logic       w;
      logic [9:0] a, ai;
      int         l;
      granted = -1;
      if (rst) begin
         for (int c = k; c < N; c++) begin
            e_g0[c] = 0; e_g1[c] = 0; e_busy[c] = 0; e_v[c] = 0;
            e_id[c] = 0; e_last[c] = 0; e_data[c] = '0; e_ra[c] = '0;
         end
         free_edge = k + 1;
         m_last    = 1'b1;
      end else if (k >= free_edge && (req0 || req1)) begin
         w       = (req0 && req1) ? !m_last : req1;
         m_last  = w;
         a       = w ? addr1 : addr0;
         l       = int'(w ? len1 : len0);
         granted = int'(w);
         if (w) e_g1[k] = 1; else e_g0[k] = 1;
         for (int i = 0; i <= l; i++) begin
            ai            = a + 10'(i);
            e_v[k+2+i]    = 1;
            e_data[k+2+i] = {2'b00, ai} + 12'd100;
            e_id[k+2+i]   = w;
            e_last[k+2+i] = (i == l);
         end
         for (int c = k; c <= k + 2 + l; c++) e_busy[c] = 1;
         for (int c = k; c < N; c++) e_ra[c] = (c <= k + l) ? a + 10'(c - k) : a + 10'(l);
         free_edge = k + l + 2;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge(cyc);
      @(negedge clk);
      check_eq("ctl{g0,g1,busy,v,id,last}", {26'd0, gnt0, gnt1, busy, rd_valid, rd_id, rd_last},
               {26'd0, e_g0[cyc], e_g1[cyc], e_busy[cyc], e_v[cyc], e_id[cyc], e_last[cyc]});
      check_eq("rd_data", {20'd0, rd_data}, {20'd0, e_data[cyc]});
      check_eq("rom_addr", {22'd0, rom_addr}, {22'd0, e_ra[cyc]});
      if (granted == 0 && !hold0) req0 = 1'b0;
      if (granted == 1 && !hold1) req1 = 1'b0;
   endtask

   task automatic random_drive();
      rst   = ($urandom_range(0, 299) == 0);
      hold0 = ($urandom_range(0, 3) == 0);
      hold1 = ($urandom_range(0, 3) == 0);
      if (!req0 && $urandom_range(0, 2) == 0) begin
         req0 = 1'b1; addr0 = 10'($urandom);
         len0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
         req1 = 1'b1; addr1 = 10'($urandom);
         len1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      end
   endtask

   initial begin
      for (int c = 0; c < N; c++) begin
         e_g0[c] = 0; e_g1[c] = 0; e_busy[c] = 0; e_v[c] = 0;
         e_id[c] = 0; e_last[c] = 0; e_data[c] = '0; e_ra[c] = '0;
      end
      cyc = -1; n_tests = 0; n_fail = 0; free_edge = 0; granted = -1; m_last = 1'b1;
      hold0 = 0; hold1 = 0;
      rst = 1'b1; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      req0 = 1; addr0 = 10'd5; len0 = 4'd3;
      repeat (10) tick();

      req0 = 1; addr0 = 10'd20; len0 = 4'd0; req1 = 1; addr1 = 10'd30; len1 = 4'd0;
      repeat (8) tick();
      req0 = 1; req1 = 1;
      repeat (8) tick();

      req1 = 1; addr1 = 10'd1022; len1 = 4'd3;
      repeat (10) tick();

      req0 = 1; addr0 = 10'd7; len0 = 4'd0;
      repeat (6) tick();

      req0 = 1; addr0 = 10'd300; len0 = 4'd15;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      req1 = 1; addr1 = 10'd50; len1 = 4'd2;
      repeat (8) tick();

      hold0 = 1; hold1 = 1;
      req0 = 1; addr0 = 10'd100; len0 = 4'd1; req1 = 1; addr1 = 10'd900; len1 = 4'd1;
      repeat (24) tick();
      hold0 = 0; hold1 = 0; req0 = 0; req1 = 0;
      repeat (6) tick();

      repeat (2000) begin
         random_drive();
         tick();
      end
      rst = 0; hold0 = 0; hold1 = 0; req0 = 0; req1 = 0;
      repeat (25) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
